// File: rtl/hazard_scoreboard_if.sv
// ============================================================================
// hazard_scoreboard_if : issue/retire/status bundle for the hazard scoreboard
// Rev 1.0 ; Err member present only when SCOREBOARD_ERR_EN is defined
// ============================================================================
`default_nettype none

interface hazard_scoreboard_if #(
  parameter int MAX_OUT = 4
);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic          IssueValid;
  logic          IssueRegWrite;
  logic          IssueLongLat;
  logic [4:0]    IssueRd;
  logic          Reg1Use;
  logic          Reg2Use;
  logic [4:0]    Reg1;
  logic [4:0]    Reg2;
  logic          RetireValid;
  logic [4:0]    RetireRd;
  logic          Stall;
  logic [CW-1:0] Outstanding;
  logic          Busy;
`ifdef SCOREBOARD_ERR_EN
  logic          Err;
`endif

  modport master (
    output IssueValid, IssueRegWrite, IssueLongLat, IssueRd,
    output Reg1Use, Reg2Use, Reg1, Reg2,
    output RetireValid, RetireRd,
    input  Stall, Outstanding, Busy
`ifdef SCOREBOARD_ERR_EN
    , input Err
`endif
  );

  modport slave (
    input  IssueValid, IssueRegWrite, IssueLongLat, IssueRd,
    input  Reg1Use, Reg2Use, Reg1, Reg2,
    input  RetireValid, RetireRd,
    output Stall, Outstanding, Busy
`ifdef SCOREBOARD_ERR_EN
    , output Err
`endif
  );
endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard : RAW/WAW/capacity stall logic for long-latency writes
// Rev 1.0 ; optional sticky Err output enabled by macro SCOREBOARD_ERR_EN
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int MAX_OUT = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  hazard_scoreboard_if.slave  bus
);
  localparam int            CW    = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_OUT);

  logic [31:0]   r_pending;
  logic [CW-1:0] r_count;
  logic [31:0]   w_pending_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_hit1, w_hit2, w_hit_rd;
  logic          w_raw1, w_raw2, w_waw, w_full;
  logic          w_stall, w_accept, w_retire;

  // A same-cycle retire of the register is forwarded, so it is not a hazard.
  assign w_hit1   = r_pending[bus.Reg1] & (bus.Reg1 != 5'd0) &
                    ~(bus.RetireValid & (bus.RetireRd == bus.Reg1));
  assign w_hit2   = r_pending[bus.Reg2] & (bus.Reg2 != 5'd0) &
                    ~(bus.RetireValid & (bus.RetireRd == bus.Reg2));
  assign w_hit_rd = r_pending[bus.IssueRd] & (bus.IssueRd != 5'd0) &
                    ~(bus.RetireValid & (bus.RetireRd == bus.IssueRd));

  assign w_raw1   = bus.Reg1Use & w_hit1;
  assign w_raw2   = bus.Reg2Use & w_hit2;
  assign w_waw    = bus.IssueRegWrite & w_hit_rd;
  assign w_full   = bus.IssueRegWrite & bus.IssueLongLat & (bus.IssueRd != 5'd0) &
                    (r_count == C_MAX) & ~bus.RetireValid;

  assign w_stall  = bus.IssueValid & (w_raw1 | w_raw2 | w_waw | w_full);
  assign w_accept = bus.IssueValid & ~w_stall & bus.IssueRegWrite &
                    bus.IssueLongLat & (bus.IssueRd != 5'd0);
  assign w_retire = bus.RetireValid & r_pending[bus.RetireRd];

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_retire) w_pending_nxt[bus.RetireRd] = 1'b0;
    // Set after clear so a same-register accept keeps the bit.
    if (w_accept) w_pending_nxt[bus.IssueRd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !w_retire && (r_count != C_MAX))
      w_count_nxt = r_count + CW'(1);
    else if (!w_accept && w_retire && (r_count != '0))
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_count   <= w_count_nxt;
    end
  end

`ifdef SCOREBOARD_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if ((bus.RetireValid && !r_pending[bus.RetireRd]) ||
             (w_accept && !w_retire && (r_count == C_MAX)))
      r_err <= 1'b1;
  end

  assign bus.Err = r_err;
`endif

  assign bus.Stall       = w_stall;
  assign bus.Outstanding = r_count;
  assign bus.Busy        = (r_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// tb_hazard_scoreboard : directed and randomized checks of hazard_scoreboard
// Rev 1.0 ; Err checks compiled only when SCOREBOARD_ERR_EN is defined
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  hazard_scoreboard_if #(.MAX_OUT(MAX_OUT)) bus ();

  hazard_scoreboard #(.MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: set of pending registers and a bounded in-flight count.
  bit [31:0] m_pend;
  int        m_cnt;
  bit        m_err;

  function automatic bit m_hit(input logic [4:0] r);
    return m_pend[r] && (r != 5'd0) && !(bus.RetireValid && bus.RetireRd == r);
  endfunction

  function automatic bit m_stall();
    bit dep, cap;
    dep = (bus.Reg1Use && m_hit(bus.Reg1)) || (bus.Reg2Use && m_hit(bus.Reg2)) ||
          (bus.IssueRegWrite && m_hit(bus.IssueRd));
    cap = bus.IssueRegWrite && bus.IssueLongLat && bus.IssueRd != 5'd0 &&
          m_cnt == MAX_OUT && !bus.RetireValid;
    return bus.IssueValid && (dep || cap);
  endfunction

  task automatic m_commit();
    bit acc, ret;
    acc = bus.IssueValid && !m_stall() && bus.IssueRegWrite && bus.IssueLongLat &&
          bus.IssueRd != 5'd0;
    ret = bus.RetireValid && m_pend[bus.RetireRd];
    if ((bus.RetireValid && !m_pend[bus.RetireRd]) || (acc && !ret && m_cnt == MAX_OUT))
      m_err = 1'b1;
    if (ret) m_pend[bus.RetireRd] = 1'b0;
    if (acc) m_pend[bus.IssueRd] = 1'b1;
    m_cnt = m_cnt + int'(acc) - int'(ret);
    if (m_cnt > MAX_OUT) m_cnt = MAX_OUT;
    if (m_cnt < 0) m_cnt = 0;
  endtask

  task automatic idle();
    bus.IssueValid = 0; bus.IssueRegWrite = 0; bus.IssueLongLat = 0; bus.IssueRd = 0;
    bus.Reg1Use = 0; bus.Reg2Use = 0; bus.Reg1 = 0; bus.Reg2 = 0;
    bus.RetireValid = 0; bus.RetireRd = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input bit ll, input bit r1u, input logic [4:0] r1);
    idle();
    bus.IssueValid = 1; bus.IssueRegWrite = 1; bus.IssueLongLat = ll; bus.IssueRd = rd;
    bus.Reg1Use = r1u; bus.Reg1 = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pend = '0; m_cnt = 0; m_err = 0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.IssueValid = 1; bus.Reg1Use = 1; bus.Reg1 = 5'd3;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.Outstanding !== 3'd0) $display("FAIL reset_outstanding: got %0d expected 0", bus.Outstanding);
    else n_pass++;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Stall !== 1'b0)
      $display("FAIL reset_busy_stall: got busy=%b stall=%b expected 0/0", bus.Busy, bus.Stall);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_raw();
    do_reset();
    issue(5'd5, 1, 0, 5'd0);
    tick();
    idle();
    bus.IssueValid = 1; bus.Reg1Use = 1; bus.Reg1 = 5'd5;
    #1;
    n_checks++;
    if (bus.Stall !== 1'b1 || bus.Outstanding !== 3'd1)
      $display("FAIL raw_stall: got stall=%b out=%0d expected 1/1", bus.Stall, bus.Outstanding);
    else n_pass++;
    bus.RetireValid = 1; bus.RetireRd = 5'd5;
    #1;
    n_checks++;
    if (bus.Stall !== 1'b0) $display("FAIL raw_retire_bypass: got stall=%b expected 0", bus.Stall);
    else n_pass++;
    tick();
    idle();
    n_checks++;
    if (bus.Outstanding !== 3'd0 || bus.Busy !== 1'b0)
      $display("FAIL raw_drain: got out=%0d busy=%b expected 0/0", bus.Outstanding, bus.Busy);
    else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i), 1, 0, 5'd0);
      tick();
    end
    issue(5'd6, 1, 0, 5'd0);
    #1;
    n_checks++;
    if (bus.Stall !== 1'b1 || bus.Outstanding !== 3'd4)
      $display("FAIL full_stall: got stall=%b out=%0d expected 1/4", bus.Stall, bus.Outstanding);
    else n_pass++;
    bus.RetireValid = 1; bus.RetireRd = 5'd1;
    #1;
    n_checks++;
    if (bus.Stall !== 1'b0) $display("FAIL full_retire_relief: got stall=%b expected 0", bus.Stall);
    else n_pass++;
    tick();
    idle();
    bus.IssueValid = 1; bus.Reg1Use = 1; bus.Reg1 = 5'd6;
    #1;
    n_checks++;
    if (bus.Outstanding !== 3'd4 || bus.Stall !== 1'b1)
      $display("FAIL full_swap: got out=%0d stall=%b expected 4/1", bus.Outstanding, bus.Stall);
    else n_pass++;
  endtask

  task automatic test_waw();
    do_reset();
    issue(5'd7, 1, 0, 5'd0);
    tick();
    issue(5'd7, 1, 0, 5'd0);
    #1;
    n_checks++;
    if (bus.Stall !== 1'b1) $display("FAIL waw_stall: got %b expected 1", bus.Stall);
    else n_pass++;
    bus.RetireValid = 1; bus.RetireRd = 5'd7;
    #1;
    n_checks++;
    if (bus.Stall !== 1'b0) $display("FAIL waw_retire_accept: got %b expected 0", bus.Stall);
    else n_pass++;
    tick();
    idle();
    bus.IssueValid = 1; bus.Reg2Use = 1; bus.Reg2 = 5'd7;
    #1;
    n_checks++;
    if (bus.Stall !== 1'b1 || bus.Outstanding !== 3'd1)
      $display("FAIL waw_set_wins: got stall=%b out=%0d expected 1/1", bus.Stall, bus.Outstanding);
    else n_pass++;
  endtask

  task automatic test_x0();
    do_reset();
    issue(5'd0, 1, 1, 5'd0);
    bus.Reg2Use = 1; bus.Reg2 = 5'd0;
    #1;
    n_checks++;
    if (bus.Stall !== 1'b0) $display("FAIL x0_stall: got %b expected 0", bus.Stall);
    else n_pass++;
    tick();
    issue(5'd9, 0, 0, 5'd0);
    tick();
    idle();
    bus.IssueValid = 1; bus.Reg1Use = 1; bus.Reg1 = 5'd9;
    #1;
    n_checks++;
    if (bus.Outstanding !== 3'd0 || bus.Stall !== 1'b0)
      $display("FAIL x0_short_untracked: got out=%0d stall=%b expected 0/0", bus.Outstanding, bus.Stall);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      issue(5'(i), 1, 0, 5'd0);
      tick();
    end
    idle();
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.Outstanding !== 3'd0 || bus.Busy !== 1'b0)
      $display("FAIL async_reset: got out=%0d busy=%b expected 0/0", bus.Outstanding, bus.Busy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus.RetireValid = 1; bus.RetireRd = 5'd1;
    tick();
    idle();
    bus.IssueValid = 1; bus.Reg1Use = 1; bus.Reg1 = 5'd2;
    #1;
    n_checks++;
    if (bus.Outstanding !== 3'd0 || bus.Stall !== 1'b0)
      $display("FAIL stale_retire: got out=%0d stall=%b expected 0/0", bus.Outstanding, bus.Stall);
    else n_pass++;
  endtask

`ifdef SCOREBOARD_ERR_EN
  task automatic test_err();
    do_reset();
    bus.RetireValid = 1; bus.RetireRd = 5'd9;
    tick();
    idle();
    tick();
    n_checks++;
    if (bus.Err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", bus.Err);
    else n_pass++;
    do_reset();
    n_checks++;
    if (bus.Err !== 1'b0) $display("FAIL err_reset: got %b expected 0", bus.Err);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    bit exp_stall;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.IssueValid    = ($urandom_range(0, 3) != 0);
      bus.IssueRegWrite = ($urandom_range(0, 3) != 0);
      bus.IssueLongLat  = ($urandom_range(0, 2) != 0);
      bus.IssueRd       = 5'($urandom_range(0, 7));
      bus.Reg1Use       = $urandom_range(0, 1) == 1;
      bus.Reg2Use       = $urandom_range(0, 1) == 1;
      bus.Reg1          = 5'($urandom_range(0, 7));
      bus.Reg2          = 5'($urandom_range(0, 7));
      bus.RetireValid   = ($urandom_range(0, 2) == 0);
      bus.RetireRd      = 5'($urandom_range(0, 7));
      @(negedge clk);
      exp_stall = m_stall();
      n_checks++;
      if (bus.Stall !== exp_stall)
        $display("FAIL rand_stall[%0d]: got %b expected %b", c, bus.Stall, exp_stall);
      else n_pass++;
      m_commit();
      tick();
      n_checks++;
      if (bus.Outstanding !== 3'(m_cnt) || bus.Busy !== (m_cnt != 0))
        $display("FAIL rand_count[%0d]: got out=%0d busy=%b expected %0d", c, bus.Outstanding, bus.Busy, m_cnt);
      else n_pass++;
`ifdef SCOREBOARD_ERR_EN
      n_checks++;
      if (bus.Err !== m_err) $display("FAIL rand_err[%0d]: got %b expected %b", c, bus.Err, m_err);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    idle();
    m_pend = '0; m_cnt = 0; m_err = 0;
    tick();
    test_reset();
    test_raw();
    test_full();
    test_waw();
    test_x0();
    test_async_reset();
`ifdef SCOREBOARD_ERR_EN
    test_err();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: MAX_OUT, default 4, maximum long-latency register writes in flight (legal range 1-31).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 IssueValid  input  1  the instruction in decode requests issue this cycle.
REQ-005 IssueRegWrite  input  1  the issuing instruction writes a destination register.
REQ-006 IssueLongLat  input  1  the destination is produced by a long-latency unit (div/load-miss) that the forwarding paths cannot cover.
REQ-007 IssueRd  input  5  destination register of the issuing instruction.
REQ-008 Reg1Use, Reg2Use  input  1 each  the corresponding source operand is read.
REQ-009 Reg1, Reg2  input  5 each  source registers of the issuing instruction.
REQ-010 RetireValid  input  1  a long-latency result is written back this cycle.
REQ-011 RetireRd  input  5  register written by that result.
REQ-012 Stall  output  1  combinational; hold decode and insert a bubble.
REQ-013 Outstanding  output  $clog2(MAX_OUT+1)  registered count of pending long-latency writes.
REQ-014 Busy  output  1  combinational; Outstanding != 0.

Function
REQ-015 Hold a 32-bit pending vector; bit 0 is never set.
REQ-016 Define hit(r) = pending[r] & (r != 0) & ~(RetireValid & RetireRd == r): a same-cycle retire clears the hazard, since writeback forwarding supplies the value.
REQ-017 Define raw1 = Reg1Use & hit(Reg1), raw2 = Reg2Use & hit(Reg2), and waw = IssueRegWrite & hit(IssueRd).
REQ-018 Define full = IssueRegWrite & IssueLongLat & (IssueRd != 0) & (Outstanding == MAX_OUT) & ~RetireValid.
REQ-019 Stall = IssueValid & (raw1 | raw2 | waw | full); Stall is 0 whenever IssueValid = 0.
REQ-020 Define accept = IssueValid & ~Stall & IssueRegWrite & IssueLongLat & (IssueRd != 0).
REQ-021 On accept, set pending[IssueRd] at the next edge.
REQ-022 On RetireValid with pending[RetireRd] = 1, clear pending[RetireRd] at the next edge.
REQ-023 If accept and retire target the same register in the same cycle, the set wins and the bit stays 1.
REQ-024 Outstanding next-state: +1 on accept only, -1 on a valid retire only, unchanged when both or neither occur.
REQ-025 Outstanding never exceeds MAX_OUT and never wraps below 0.
REQ-026 A retire to a non-pending register, or to x0, changes no state.
REQ-027 Short-latency writes and writes to x0 never touch the scoreboard.
REQ-028 Issue-to-visible-hazard latency is 1 cycle: an instruction issued in cycle N stalls a dependent instruction in cycle N+1.

Reset
REQ-029 While rst = 1: pending = 0, Outstanding = 0, and Err = 0 when present; therefore Busy = 0 and Stall = 0.
REQ-030 Assertion of rst mid-operation discards all in-flight entries immediately, without waiting for a clock edge.
REQ-031 Retires arriving after reset for discarded entries are ignored per REQ-026.

Configuration
REQ-032 Macro SCOREBOARD_ERR_EN.
REQ-033 Defined: add output Err (1 bit, registered, sticky until rst), set on a retire to a non-pending register, or on an accept when Outstanding == MAX_OUT.
REQ-034 Not defined: no Err port, and illegal retires are silently ignored.

Verification
REQ-035 Issue long-latency write to x5, then in the next cycle present Reg1 = 5, Reg1Use = 1 -> Stall = 1 and Outstanding = 1; retire x5 in that same cycle -> Stall = 0.
REQ-036 Issue long-latency writes to x1-x4 (MAX_OUT = 4), then a fifth to x6 -> Stall = 1; with RetireValid = 1 in the same cycle -> Stall = 0 and Outstanding stays 4.
REQ-037 x7 pending, issue a new long-latency write to x7 -> Stall = 1 (WAW); retire x7 and issue in the same cycle -> accepted and pending[7] stays 1.
REQ-038 Issue a long-latency write to x0, and a source read of x0 -> no stall, Outstanding = 0.
REQ-039 Three entries pending, assert rst asynchronously mid-cycle -> Outstanding = 0 and Busy = 0 before the next edge; a later retire of x1 leaves state 0.
REQ-040 With SCOREBOARD_ERR_EN defined, retire x9 while not pending -> Err = 1 after the edge, held until rst.
